// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch sequencer driving an external program counter.
//
// Cycle flow: IDLE -> FETCH -> WAIT_MEM -> ISSUE -> FETCH ... with REDIRECT
// inserted after an accepted jump and HALTED after a halt at the handshake.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   run                 level, leaves IDLE when high
//   halt                sampled only at the instr handshake
//   pc                  current counter value (from the external counter)
//   load_sig, load_val  one-cycle counter load strobe and value
//   inc_sig             one-cycle counter increment strobe
//   mem_req, mem_addr   instruction read request (level) and address
//   mem_ack, mem_data   one-cycle read completion and data
//   instr, instr_pc     fetched instruction and its address
//   instr_valid/ready   handshake to the consumer
//   jmp_req, jmp_addr   redirect request and target
//   busy                high outside IDLE and HALTED
//   fsm_state           debug view of the state register
//
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid and instr_ready are both 1. While instr_valid is 1 and no
// transfer occurs, instr and instr_pc are held. instr_valid only drops
// after a transfer or when an accepted jump abandons the instruction.

module pc_sequencer #(
  parameter int WIDTH  = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              halt,
  input  logic [WIDTH:0]    pc,
  output logic              load_sig,
  output logic              inc_sig,
  output logic [WIDTH:0]    load_val,
  output logic              mem_req,
  output logic [WIDTH:0]    mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] instr,
  output logic [WIDTH:0]    instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jmp_req,
  input  logic [WIDTH:0]    jmp_addr,
  output logic              busy,
  output logic [2:0]        fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_MEM = 3'd2,
    S_ISSUE    = 3'd3,
    S_REDIRECT = 3'd4,
    S_HALTED   = 3'd5
  } state_t;

  state_t         state;
  logic           jmp_pending;  // jump seen while a read is in flight
  logic [WIDTH:0] jmp_target;   // latched target of the accepted jump

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      load_sig    <= 1'b0;
      inc_sig     <= 1'b0;
      load_val    <= '0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      jmp_pending <= 1'b0;
      jmp_target  <= '0;
    end else begin
      // Strobes are single-cycle pulses by default.
      load_sig <= 1'b0;
      inc_sig  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (jmp_req) begin
            jmp_target <= jmp_addr;
            load_val   <= jmp_addr;
            load_sig   <= 1'b1;
            state      <= S_REDIRECT;
          end else begin
            mem_addr <= pc;
            mem_req  <= 1'b1;
            state    <= S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          if (mem_ack) begin
            mem_req     <= 1'b0;
            jmp_pending <= 1'b0;
            if (jmp_req || jmp_pending) begin
              // Read finished but a jump is owed: drop the data.
              load_val   <= jmp_req ? jmp_addr : jmp_target;
              jmp_target <= jmp_req ? jmp_addr : jmp_target;
              load_sig   <= 1'b1;
              state      <= S_REDIRECT;
            end else begin
              instr       <= mem_data;
              instr_pc    <= mem_addr;
              instr_valid <= 1'b1;
              inc_sig     <= 1'b1;
              state       <= S_ISSUE;
            end
          end else if (jmp_req) begin
            jmp_pending <= 1'b1;
            jmp_target  <= jmp_addr;
          end
        end
        S_ISSUE: begin
          if (instr_valid && instr_ready) begin
            instr_valid <= 1'b0;
            if (halt) begin
              // halt wins over a simultaneous jump
              state <= S_HALTED;
              busy  <= 1'b0;
            end else if (jmp_req) begin
              jmp_target <= jmp_addr;
              load_val   <= jmp_addr;
              load_sig   <= 1'b1;
              state      <= S_REDIRECT;
            end else begin
              state <= S_FETCH;
            end
          end else if (jmp_req) begin
            // Unconsumed instruction is abandoned.
            instr_valid <= 1'b0;
            jmp_target  <= jmp_addr;
            load_val    <= jmp_addr;
            load_sig    <= 1'b1;
            state       <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          // Counter loads at the end of this cycle; FETCH then sees it.
          state <= S_FETCH;
        end
        S_HALTED: begin
          if (!run) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Contains a program counter model, an instruction memory responder,
// a cycle vector table, directed sequences and a randomized phase
// checked against a transaction-level reference of the fetch stream.

module tb_pc_sequencer;

  localparam int WIDTH  = 11;
  localparam int DATA_W = 16;
  localparam int AW     = WIDTH + 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic              run, halt;
  logic [AW-1:0]     pc;
  logic              load_sig, inc_sig;
  logic [AW-1:0]     load_val;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] instr;
  logic [AW-1:0]     instr_pc;
  logic              instr_valid, instr_ready;
  logic              jmp_req;
  logic [AW-1:0]     jmp_addr;
  logic              busy;
  logic [2:0]        fsm_state;

  pc_sequencer #(.WIDTH(WIDTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .run(run), .halt(halt), .pc(pc),
    .load_sig(load_sig), .inc_sig(inc_sig), .load_val(load_val),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .jmp_req(jmp_req), .jmp_addr(jmp_addr), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- program counter model ----------------
  always @(posedge clk or negedge rst) begin
    if (!rst)          pc <= '0;
    else if (load_sig) pc <= load_val;
    else if (inc_sig)  pc <= pc + 12'd1;
  end

  // ---------------- memory contents ----------------
  function automatic logic [DATA_W-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 12'd7) return 16'h1234;
    return {a[3:0], a} ^ 16'h5000;
  endfunction

  // ---------------- memory responder / table source ----------------
  logic              mem_en;   // 1: responder drives mem_ack, 0: vector table does
  logic              rsp_ack, tbl_ack;
  logic [DATA_W-1:0] rsp_data, tbl_data;
  int                mem_lat;
  logic              mem_rand;
  assign mem_ack  = mem_en ? rsp_ack : tbl_ack;
  assign mem_data = mem_en ? rsp_data : tbl_data;

  initial begin
    int cnt;
    cnt = 0;
    rsp_ack = 1'b0;
    rsp_data = '0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        if (!rst) begin
          rsp_ack = 1'b0;
          cnt = 0;
        end else if (rsp_ack) begin
          rsp_ack = 1'b0;
        end else if (mem_req) begin
          cnt++;
          if (cnt >= mem_lat) begin
            rsp_ack  = 1'b1;
            rsp_data = mem_word(mem_addr);
            cnt = 0;
            if (mem_rand) mem_lat = $urandom_range(1, 4);
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"},        32'(busy), 32'd0);
    chk({tag, "_mem_req"},     32'(mem_req), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_load_sig"},    32'(load_sig), 32'd0);
    chk({tag, "_inc_sig"},     32'(inc_sig), 32'd0);
    chk({tag, "_mem_addr"},    32'(mem_addr), 32'd0);
    chk({tag, "_instr"},       32'(instr), 32'd0);
    chk({tag, "_instr_pc"},    32'(instr_pc), 32'd0);
    chk({tag, "_load_val"},    32'(load_val), 32'd0);
    chk({tag, "_state"},       32'(fsm_state), 32'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    run = 1'b0;
    halt = 1'b0;
    jmp_req = 1'b0;
    jmp_addr = '0;
    instr_ready = 1'b0;
    tbl_ack = 1'b0;
    tbl_data = '0;
    repeat (2) @(negedge clk);
    check_idle("in_reset");
    rst = 1'b1;
  endtask

  // Wait for a rising instr_valid (prev tracks the previous sample).
  task automatic wait_valid_rise(input string tag, inout logic prev, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (instr_valid && !prev) ok = 1'b1;
      prev = instr_valid;
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_mem_req(input string tag, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (mem_req) ok = 1'b1;
    end
    if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  // ---------------- cycle vector table ----------------
  typedef struct {
    logic              run, ack;
    logic [DATA_W-1:0] data;
    logic              ready, jmp;
    logic [AW-1:0]     jaddr;
    logic              halt;
    logic              busy, req;
    logic [AW-1:0]     maddr;
    logic              valid;
    logic [DATA_W-1:0] ins;
    logic [AW-1:0]     ipc;
    logic              inc, load;
    logic [AW-1:0]     lval;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input vec_t v);
    tbl.push_back(v);
  endtask

  task automatic run_table();
    vec_t v;
    // Fields: run ack data ready jmp jaddr halt | busy req maddr valid ins ipc inc load lval
    add('{1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b1, 16'h1111, 1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h1111, 12'h0,   1'b1, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h1111, 12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b1, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h1,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    // jump on the ack cycle of WAIT_MEM: 0x2222 is discarded
    add('{1'b1, 1'b1, 16'h2222, 1'b0, 1'b1, 12'h0A0, 1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b1, 12'h0A0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h0A0, 1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h3333, 12'h0A0, 1'b1, 1'b0, 12'h0});
    // halt together with jump at the handshake: halted, no load
    add('{1'b1, 1'b0, 16'h0,    1'b1, 1'b1, 12'h005, 1'b1, 1'b0, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b0, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b0, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    // resumes at pc+1
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h0A1, 1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h4444, 12'h0A1, 1'b1, 1'b0, 12'h0});
    // jump in ISSUE without handshake
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 12'h105, 1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b1, 12'h105});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h105, 1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b1, 16'h5555, 1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h5555, 12'h105, 1'b1, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b1, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    // jump in FETCH
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b1, 12'h7FF, 1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b1, 12'h7FF});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h7FF, 1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b1, 16'h6666, 1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h6666, 12'h7FF, 1'b1, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b1, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h800, 1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b1, 16'h7777, 1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h7777, 12'h800, 1'b1, 1'b0, 12'h0});
    // handshake plus jump: consumed, then redirect to the top address
    add('{1'b1, 1'b0, 16'h0,    1'b1, 1'b1, 12'hFFF, 1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b1, 12'hFFF});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'hFFF, 1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    add('{1'b1, 1'b1, 16'h8888, 1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b1, 16'h8888, 12'hFFF, 1'b1, 1'b0, 12'h0});
    add('{1'b1, 1'b0, 16'h0,    1'b1, 1'b0, 12'h0,   1'b0, 1'b1, 1'b0, 12'h0,   1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});
    // pc wrapped from 0xFFF to 0
    add('{1'b1, 1'b0, 16'h0,    1'b0, 1'b0, 12'h0,   1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 16'h0,    12'h0,   1'b0, 1'b0, 12'h0});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      run = v.run; tbl_ack = v.ack; tbl_data = v.data; instr_ready = v.ready;
      jmp_req = v.jmp; jmp_addr = v.jaddr; halt = v.halt;
      @(negedge clk);
      chk($sformatf("row%0d_busy", i),        32'(busy), 32'(v.busy));
      chk($sformatf("row%0d_mem_req", i),     32'(mem_req), 32'(v.req));
      chk($sformatf("row%0d_instr_valid", i), 32'(instr_valid), 32'(v.valid));
      chk($sformatf("row%0d_inc_sig", i),     32'(inc_sig), 32'(v.inc));
      chk($sformatf("row%0d_load_sig", i),    32'(load_sig), 32'(v.load));
      if (v.req) chk($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(v.maddr));
      if (v.valid) begin
        chk($sformatf("row%0d_instr", i),    32'(instr), 32'(v.ins));
        chk($sformatf("row%0d_instr_pc", i), 32'(instr_pc), 32'(v.ipc));
      end
      if (v.load) chk($sformatf("row%0d_load_val", i), 32'(load_val), 32'(v.lval));
    end
    tbl_ack = 1'b0;
    jmp_req = 1'b0;
    halt = 1'b0;
  endtask

  // ---------------- directed: in-order fetch and consumer stall ----------------
  task automatic seq_in_order();
    int got, incs;
    logic prev;
    do_reset();
    mem_rand = 1'b0;
    mem_lat = 2;
    run = 1'b1;
    instr_ready = 1'b1;
    got = 0;
    incs = 0;
    prev = 1'b0;
    for (int c = 0; c < 400 && got < 8; c++) begin
      @(negedge clk);
      if (inc_sig) incs++;
      if (instr_valid && !prev) begin
        chk("order_instr_pc", 32'(instr_pc), got);
        chk("order_instr", 32'(instr), 32'(mem_word(12'(got))));
        got++;
        if (instr_pc == 12'd7) begin
          instr_ready = 1'b0;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (inc_sig) incs++;
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", 32'(instr), 32'h1234);
            chk("stall_pc", 32'(instr_pc), 32'd7);
            chk("stall_mem_req", 32'(mem_req), 32'd0);
          end
          instr_ready = 1'b1;
        end
      end
      prev = instr_valid;
    end
    chk("order_count", got, 32'd8);
    chk("order_inc_count", incs, 32'd8);
  endtask

  // ---------------- directed: jump during ISSUE ----------------
  task automatic seq_jump_issue();
    logic prev;
    bit ok;
    int loads;
    prev = instr_valid;
    wait_valid_rise("jmp_issue_wait", prev, ok);
    if (ok) begin
      chk("jmp_issue_cur_pc", 32'(instr_pc), 32'd8);
      jmp_req = 1'b1;
      jmp_addr = 12'd261;
      instr_ready = 1'b1;
      @(negedge clk);
      jmp_req = 1'b0;
      chk("jmp_issue_load_sig", 32'(load_sig), 32'd1);
      chk("jmp_issue_load_val", 32'(load_val), 32'd261);
      chk("jmp_issue_valid_drop", 32'(instr_valid), 32'd0);
      loads = 0;
      ok = 1'b0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk);
        if (load_sig) loads++;
        if (mem_req) ok = 1'b1;
      end
      chk("jmp_issue_fetch_seen", 32'(ok), 32'd1);
      chk("jmp_issue_extra_loads", loads, 32'd0);
      chk("jmp_issue_mem_addr", 32'(mem_addr), 32'd261);
      prev = instr_valid;
      wait_valid_rise("jmp_issue_next", prev, ok);
      if (ok) begin
        chk("jmp_issue_instr_pc", 32'(instr_pc), 32'd261);
        chk("jmp_issue_instr", 32'(instr), 32'(mem_word(12'd261)));
      end
    end
  endtask

  // ---------------- directed: reset during WAIT_MEM ----------------
  task automatic seq_reset_wait();
    bit ok;
    wait_mem_req("rst_wait", ok);
    if (ok) begin
      #2;
      rst = 1'b0;
      run = 1'b0;
      #1;
      chk("rst_async_mem_req", 32'(mem_req), 32'd0);
      chk("rst_async_valid", 32'(instr_valid), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check_idle("post_rst");
      end
      run = 1'b1;
      wait_mem_req("post_rst_fetch", ok);
      if (ok) chk("post_rst_mem_addr", 32'(mem_addr), 32'd0);
    end
  endtask

  // ---------------- randomized phase with reference model ----------------
  // Reference: the stream of presented instructions follows pc+1 after each
  // consumed instruction, and restarts at the target of each accepted jump;
  // every accepted jump yields exactly one load of its target.
  task automatic run_random();
    logic [AW-1:0] exp_addr, ja;
    int presents, incs;
    bit jumped;
    logic prev;
    do_reset();
    mem_rand = 1'b1;
    mem_lat = 2;
    exp_q.delete();
    exp_addr = '0;
    presents = 0;
    incs = 0;
    jumped = 1'b0;
    prev = 1'b0;
    run = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (inc_sig) incs++;
      if (load_sig) begin
        chk("rnd_load_inc_overlap", 32'(inc_sig), 32'd0);
        if (exp_q.size() == 0) chk("rnd_load_unexpected", 32'd1, 32'd0);
        else chk("rnd_load_val", 32'(load_val), 32'(exp_q.pop_front()));
      end
      if (instr_valid && !prev) begin
        presents++;
        chk("rnd_instr_pc", 32'(instr_pc), 32'(exp_addr));
        chk("rnd_instr", 32'(instr), 32'(mem_word(exp_addr)));
      end
      if (!mem_req) jumped = 1'b0;
      instr_ready = ($urandom_range(0, 9) < 7);
      jmp_req = 1'b0;
      if (c < 2950) begin
        if (instr_valid && $urandom_range(0, 9) == 0) begin
          ja = 12'($urandom);
          jmp_req = 1'b1;
          jmp_addr = ja;
          exp_q.push_back(ja);
          exp_addr = ja;
        end else if (mem_req && !jumped && $urandom_range(0, 19) == 0) begin
          ja = 12'($urandom);
          jmp_req = 1'b1;
          jmp_addr = ja;
          exp_q.push_back(ja);
          exp_addr = ja;
          jumped = 1'b1;
        end
      end
      if (!jmp_req && instr_valid && instr_ready) exp_addr = exp_addr + 12'd1;
      prev = instr_valid;
    end
    jmp_req = 1'b0;
    chk("rnd_inc_count", incs, presents);
    chk("rnd_loads_drained", exp_q.size(), 32'd0);
    chk("rnd_progress", 32'(presents > 100), 32'd1);
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b0;
    mem_en = 1'b0;
    mem_rand = 1'b0;
    mem_lat = 2;
    do_reset();
    run_table();
    mem_en = 1'b1;
    seq_in_order();
    seq_jump_issue();
    seq_reset_wait();
    run_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
